mem_access_sequencer: RTL and testbench
=======================================

# mem_access_sequencer

MEM-stage controller that sequences every data-memory operation of the pipelined LC-3b onto the single D-cache port. It turns the control word's memory fields (read, write, byte enable, LDI/STI flags) into cache requests. It runs the two-access indirect sequence for LDI/STI and holds the pipeline with `stall` until the final cache response arrives.

## Interface
Parameters:
- none; widths come from `lc3b_types` (`lc3b_word` = 16 bits, `lc3b_mem_wmask` = 2 bits)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `valid`  in  1  an instruction occupies the MEM stage
- `mem_read`  in  1  control word read strobe (set for LDR/LDB/LDI/STI/TRAP)
- `mem_write`  in  1  control word write strobe (STR/STB)
- `is_ldi`  in  1  indirect load
- `is_sti`  in  1  indirect store
- `mem_byte_enable`  in  2  byte mask for single writes
- `addr`  in  16  effective address from EX/MEM
- `wdata`  in  16  store data (already byte-replicated for STB)
- `dmem_read`  out  1  D-cache read request
- `dmem_write`  out  1  D-cache write request
- `dmem_byte_enable`  out  2  D-cache write mask
- `dmem_address`  out  16  D-cache address
- `dmem_wdata`  out  16  D-cache write data
- `dmem_rdata`  in  16  D-cache read data, valid with `dmem_resp`
- `dmem_resp`  in  1  one-cycle completion pulse for the current request
- `rdata`  out  16  load result to MEM/WB; equals `dmem_rdata`
- `stall`  out  1  hold all pipeline registers this cycle

## Operation
- Request present: `req = valid & (mem_read | mem_write)`.
- States: `SEQ_IDLE` (first or only access), `SEQ_IND2` (second access of LDI/STI).
- In `SEQ_IDLE` with `req`:
  - Strobes are combinational from the inputs.
  - `dmem_address = addr`.
  - `dmem_read = mem_read`; `dmem_write = mem_write`.
  - `dmem_byte_enable = mem_byte_enable` on writes, 2'b11 on reads.
  - `dmem_wdata = wdata`.
- In `SEQ_IDLE`, indirect (`is_ldi | is_sti`): the first access is always a word read with `dmem_address = {addr[15:1],1'b0}`. On `dmem_resp`:
  - `ptr <= dmem_rdata`.
  - `ind_store <= is_sti`.
  - Go to `SEQ_IND2`.
- In `SEQ_IND2`:
  - `dmem_address = {ptr[15:1],1'b0}`; `dmem_byte_enable = 2'b11`.
  - If `ind_store`: `dmem_write = 1`, `dmem_wdata = wdata`. Otherwise: `dmem_read = 1`.
  - On `dmem_resp`, go to `SEQ_IDLE`.
- Final phase is `SEQ_IDLE` for a non-indirect access and `SEQ_IND2` for an indirect one.
- `stall = req & ~(final_phase & dmem_resp)`. It is Mealy and drops in the same cycle as the final response.
- `rdata = dmem_rdata` at all times. MEM/WB captures it on the cycle `stall` drops.
- No request (`~req` in `SEQ_IDLE`): all strobes 0, `stall = 0`, address and data outputs 0.
- Byte-lane selection for LDB is downstream, not done here.

## Timing
- Reset values: state `SEQ_IDLE`, `ptr = 0`, `ind_store = 0`.
- While `reset` is high, `dmem_read`, `dmem_write` and `stall` are forced to 0.
- Reset mid-`SEQ_IND2`: return to `SEQ_IDLE`. The outstanding cache transaction is abandoned.
- Latency:
  - Single access takes N cycles, where N is the cache response latency. A cache hit with same-cycle `dmem_resp` gives zero stall cycles.
  - Indirect access takes N1+N2 cycles. The second request is issued the cycle after the first `dmem_resp`.
- Handshake:
  - Request strobes stay asserted and stable until `dmem_resp`.
  - They are never asserted in the cycle after a final `dmem_resp` unless a new instruction is in MEM.
- Inputs are stable while `stall` is high, because the pipeline is frozen. The sequencer uses registered `ind_store` and `ptr` in `SEQ_IND2` regardless.
- `dmem_resp` while no request is outstanding is ignored; the state is unchanged.
- Back-to-back memory instructions: a new `req` in the cycle after the final response starts immediately from `SEQ_IDLE`.

## Structure
- Add `typedef enum logic {SEQ_IDLE, SEQ_IND2} lc3b_mem_seq_state` to `lc3b_types`.
- Arrange the module as one `always_ff` block for state, `ptr` and `ind_store`, and one `always_comb` block for the strobes, `stall` and next state.
- No sub-module.

## Test plan
- LDR at `addr` 0x1234, cache returns 0xBEEF with `dmem_resp` 3 cycles later:
  - `dmem_read` stays 1 for 3 cycles with `dmem_address` 0x1234.
  - `stall` is 1,1,0; `rdata` is 0xBEEF on the last cycle.
- STB with `mem_byte_enable` 2'b10, `wdata` 0x5A5A, same-cycle `dmem_resp`: `dmem_write` 1, mask 2'b10, `stall` 0 throughout.
- LDI at `addr` 0x3001, first read returns 0x4000, second returns 0x00FF:
  - First request goes to address 0x3000, second to 0x4000.
  - `stall` drops only with the second `dmem_resp`; `rdata` is 0x00FF.
- STI at `addr` 0x2000, pointer read returns 0x6002, `wdata` 0x1357: the second request is a write to 0x6002 with mask 2'b11 and data 0x1357.
- `reset` asserted in `SEQ_IND2`: the next cycle shows state `SEQ_IDLE`, all strobes 0 and `stall` 0. A subsequent LDR proceeds normally.
- Spurious `dmem_resp` with `valid` 0: no strobe, state stays `SEQ_IDLE`, `stall` 0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the MEM-stage sequencer.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_IND2 = 1'b1
    } lc3b_mem_seq_state;

    localparam lc3b_mem_wmask WMASK_WORD = 2'b11;

    function automatic lc3b_word word_align(input lc3b_word a);
        return {a[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_access_sequencer.sv
// MEM-stage D-cache sequencer: single accesses plus the two-access LDI/STI
// indirect sequence, holding the pipeline until the final response.
//
// Handshake: a request (dmem_read or dmem_write) is held with stable address,
// mask and data until dmem_resp pulses for one cycle; dmem_resp with no
// outstanding request is ignored.
module mem_access_sequencer
    import lc3b_types::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              is_ldi,
    input  logic              is_sti,
    input  lc3b_mem_wmask     mem_byte_enable,
    input  lc3b_word          addr,
    input  lc3b_word          wdata,
    output logic              dmem_read,
    output logic              dmem_write,
    output lc3b_mem_wmask     dmem_byte_enable,
    output lc3b_word          dmem_address,
    output lc3b_word          dmem_wdata,
    input  lc3b_word          dmem_rdata,
    input  logic              dmem_resp,
    output lc3b_word          rdata,
    output logic              stall,
    output lc3b_mem_seq_state seq_state
);

    lc3b_mem_seq_state state_q, state_d;
    lc3b_word          ptr_q, ptr_d;
    logic              ind_store_q, ind_store_d;

    logic req;
    logic indirect;

    assign req       = valid & (mem_read | mem_write);
    assign indirect  = is_ldi | is_sti;
    assign rdata     = dmem_rdata;
    assign seq_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEQ_IDLE;
            ptr_q       <= '0;
            ind_store_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ind_store_q <= ind_store_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        ind_store_d      = ind_store_q;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_byte_enable = '0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        stall            = 1'b0;

        unique case (state_q)
            SEQ_IDLE: begin
                if (req) begin
                    dmem_wdata = wdata;
                    if (indirect) begin
                        // Pointer fetch: always an aligned word read, never final.
                        dmem_read        = 1'b1;
                        dmem_address     = word_align(addr);
                        dmem_byte_enable = WMASK_WORD;
                        stall            = 1'b1;
                        if (dmem_resp) begin
                            ptr_d       = dmem_rdata;
                            ind_store_d = is_sti;
                            state_d     = SEQ_IND2;
                        end
                    end else begin
                        dmem_read        = mem_read;
                        dmem_write       = mem_write;
                        dmem_address     = addr;
                        dmem_byte_enable = mem_write ? mem_byte_enable : WMASK_WORD;
                        stall            = ~dmem_resp;
                    end
                end
            end
            SEQ_IND2: begin
                // Registered pointer and direction drive the second access.
                dmem_address     = word_align(ptr_q);
                dmem_byte_enable = WMASK_WORD;
                if (ind_store_q) begin
                    dmem_write = 1'b1;
                    dmem_wdata = wdata;
                end else begin
                    dmem_read  = 1'b1;
                end
                stall = req & ~dmem_resp;
                if (dmem_resp) begin
                    state_d = SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase

        if (reset) begin
            dmem_read  = 1'b0;
            dmem_write = 1'b0;
            stall      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: a byte-addressed cache model with
// random latency, a reference model of expected cache requests and results.
module tb_mem_access_sequencer;
    import lc3b_types::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid, mem_read, mem_write, is_ldi, is_sti;
    logic [1:0]        mem_byte_enable;
    logic [15:0]       addr, wdata;
    logic              dmem_read, dmem_write;
    logic [1:0]        dmem_byte_enable;
    logic [15:0]       dmem_address, dmem_wdata, dmem_rdata, rdata;
    logic              dmem_resp, stall;
    lc3b_mem_seq_state seq_state;

    always #5 clk = ~clk;

    mem_access_sequencer dut (
        .clk(clk), .reset(reset), .valid(valid), .mem_read(mem_read),
        .mem_write(mem_write), .is_ldi(is_ldi), .is_sti(is_sti),
        .mem_byte_enable(mem_byte_enable), .addr(addr), .wdata(wdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_byte_enable(dmem_byte_enable), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .rdata(rdata), .stall(stall), .seq_state(seq_state)
    );

    localparam int RW = 35;            // {write, mask, address, write data}
    logic [RW-1:0] exp_q[$];            // expected cache requests in order
    logic [18:0]   res_q[$];            // {access count, is_load, load value}
    logic [7:0]    mem [65536];
    int            compared = 0, mismatched = 0;
    int            force_lat = -1;
    logic          spur = 1'b0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_at(input logic [15:0] a);
        logic [15:0] w;
        w = {a[15:1], 1'b0};
        return {mem[w + 16'd1], mem[w]};
    endfunction

    // Cache model: picks a latency when a request appears, answers at negedge.
    initial begin
        int cnt;
        logic busy;
        logic [15:0] w;
        busy = 1'b0; cnt = 0;
        dmem_resp = 1'b0; dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 1'b0;
            end else if (dmem_read || dmem_write) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                end
                if (cnt == 0) begin
                    busy = 1'b0;
                    dmem_resp = 1'b1;
                    if (dmem_read) begin
                        dmem_rdata = word_at(dmem_address);
                    end else begin
                        w = {dmem_address[15:1], 1'b0};
                        if (dmem_byte_enable[0]) mem[w]         = dmem_wdata[7:0];
                        if (dmem_byte_enable[1]) mem[w + 16'd1] = dmem_wdata[15:8];
                        dmem_rdata = 16'($urandom);
                    end
                end else begin
                    cnt--;
                end
            end else if (spur) begin
                dmem_resp  = 1'b1;
                dmem_rdata = 16'($urandom);
            end
            if (dmem_resp) begin
                @(posedge clk);
                #1 dmem_resp = 1'b0;
            end
        end
    end

    // Monitor: pops expected requests on each new cache request and expected
    // results when the pipeline is released.
    initial begin
        logic prev_active, prev_resp, active;
        logic [RW-1:0] cur, act;
        logic [18:0] res;
        int resp_cnt;
        prev_active = 1'b0; prev_resp = 1'b0; resp_cnt = 0; cur = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_active = 1'b0; prev_resp = 1'b0; resp_cnt = 0;
            end else begin
                active = dmem_read | dmem_write;
                act = {dmem_write, dmem_byte_enable, dmem_address,
                       dmem_write ? dmem_wdata : 16'h0};
                if (!valid) check("idle_strobe", {39'b0, active}, 40'b0);
                if (active && (!prev_active || prev_resp)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_request", {5'b0, act}, 40'b0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("request", {5'b0, act}, {5'b0, cur});
                    end
                end else if (active) begin
                    check("request_stable", {5'b0, act}, {5'b0, cur});
                end
                if (active && dmem_resp) resp_cnt++;
                if (valid && (mem_read || mem_write) && !stall) begin
                    if (res_q.size() == 0) begin
                        check("unexpected_release", 40'd1, 40'd0);
                    end else begin
                        res = res_q.pop_front();
                        check("access_count", 40'(resp_cnt), 40'(res[18:17]));
                        if (res[16]) check("load_data", {24'b0, rdata}, {24'b0, res[15:0]});
                    end
                    resp_cnt = 0;
                end
                prev_active = active;
                prev_resp   = dmem_resp;
            end
        end
    end

    // kind: 0 LDR/LDB, 1 STR/STB, 2 LDI, 3 STI
    task automatic issue(input int kind, input logic [15:0] a, input logic [1:0] be,
                         input logic [15:0] wd, input bit expect_done);
        logic [15:0] p;
        bit done;
        @(posedge clk);
        #1;
        valid = 1'b1; mem_read = (kind != 1); mem_write = (kind == 1);
        is_ldi = (kind == 2); is_sti = (kind == 3);
        mem_byte_enable = be; addr = a; wdata = wd;
        p = word_at(a);
        case (kind)
            0: begin
                exp_q.push_back({1'b0, 2'b11, a, 16'h0});
                if (expect_done) res_q.push_back({2'd1, 1'b1, word_at(a)});
            end
            1: begin
                exp_q.push_back({1'b1, be, a, wd});
                if (expect_done) res_q.push_back({2'd1, 1'b0, 16'h0});
            end
            default: begin
                exp_q.push_back({1'b0, 2'b11, a[15:1], 1'b0, 16'h0});
                if (kind == 2) begin
                    exp_q.push_back({1'b0, 2'b11, p[15:1], 1'b0, 16'h0});
                    if (expect_done) res_q.push_back({2'd2, 1'b1, word_at(p)});
                end else begin
                    exp_q.push_back({1'b1, 2'b11, p[15:1], 1'b0, wd});
                    if (expect_done) res_q.push_back({2'd2, 1'b0, 16'h0});
                end
            end
        endcase
        if (expect_done) begin
            done = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                #2;
                if (!stall) begin
                    done = 1;
                    break;
                end
            end
            if (!done) check("release_timeout", 40'd0, 40'd1);
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; is_ldi = 1'b0; is_sti = 1'b0;
    endtask

    initial begin
        bit seen;
        int kind;
        logic [1:0] be;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h1234] = 8'hEF; mem[16'h1235] = 8'hBE;
        mem[16'h3000] = 8'h00; mem[16'h3001] = 8'h40;
        mem[16'h4000] = 8'hFF; mem[16'h4001] = 8'h00;
        mem[16'h2000] = 8'h02; mem[16'h2001] = 8'h60;

        reset = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        is_ldi = 1'b0; is_sti = 1'b0; mem_byte_enable = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #2;
        check("reset_state", {39'b0, seq_state}, {39'b0, SEQ_IDLE});
        check("reset_outputs", {18'b0, dmem_read, dmem_write, stall, dmem_address, dmem_wdata[2:0]}, 40'b0);

        force_lat = 2; issue(0, 16'h1234, 2'b11, 16'h0, 1);
        force_lat = 0; issue(1, 16'h0100, 2'b10, 16'h5A5A, 1);
        force_lat = -1; issue(2, 16'h3001, 2'b11, 16'h0, 1);
        issue(3, 16'h2000, 2'b11, 16'h1357, 1);
        go_idle();
        check("sti_stored", {24'b0, word_at(16'h6002)}, 40'h1357);

        // Reset while the second indirect access is outstanding.
        force_lat = 1;
        issue(2, 16'h3001, 2'b11, 16'h0, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            if (seq_state == SEQ_IND2) begin
                seen = 1;
                break;
            end
        end
        check("reached_ind2", {39'b0, seen}, 40'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #2;
        check("reset_strobes", {37'b0, dmem_read, dmem_write, stall}, 40'b0);
        @(posedge clk);
        #1;
        reset = 1'b0; valid = 1'b0; mem_read = 1'b0; is_ldi = 1'b0;
        @(negedge clk);
        #2;
        check("abort_state", {39'b0, seq_state}, {39'b0, SEQ_IDLE});
        check("abort_strobes", {37'b0, dmem_read, dmem_write, stall}, 40'b0);
        force_lat = -1;
        issue(0, 16'h1234, 2'b11, 16'h0, 1);
        go_idle();

        // Spurious response with nothing in MEM.
        @(posedge clk);
        #1 spur = 1'b1;
        @(negedge clk);
        #2;
        spur = 1'b0;
        check("spur_resp_seen", {39'b0, dmem_resp}, 40'd1);
        check("spur_strobes", {37'b0, dmem_read, dmem_write, stall}, 40'b0);
        @(negedge clk);
        #2;
        check("spur_state", {39'b0, seq_state}, {39'b0, SEQ_IDLE});

        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 3));
            be = 2'($urandom_range(1, 3));
            issue(kind, 16'($urandom), be, 16'($urandom), 1);
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();
        repeat (4) @(posedge clk);
        check("req_queue_drained", 40'(exp_q.size()), 40'd0);
        check("res_queue_drained", 40'(res_q.size()), 40'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
